// File: rtl/fft_sdf_stage_ctrl.sv
// Control sequencer for one radix-2 SDF (BF2I) FFT stage: butterfly enable/select, output framing, twiddle address.
// Optional FFT_CTRL_BACK2BACK_EN: a new frame may start in DRAIN before its first advance.
module fft_sdf_stage_ctrl #(
    parameter int  N_POINT = 64,
    parameter int  STAGE   = 0,
    parameter int  BF_LAT  = 1,
    localparam int TW_W    = $clog2(N_POINT) - 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            in_sof,
    output logic            in_ready,
    input  logic            out_ready,
    output logic            bf_en,
    output logic            bf_sel,
    output logic            out_valid,
    output logic            out_sof,
    output logic            out_eof,
    output logic [TW_W-1:0] tw_addr,
    output logic            busy,
    output logic            err_sof
);
    localparam int D         = N_POINT >> (STAGE + 1);
    localparam int CNT_W     = $clog2(N_POINT);
    localparam int SEL_BIT   = $clog2(D);
    localparam int DRAIN_LEN = D + BF_LAT;
    localparam int DC_W      = $clog2(DRAIN_LEN + 1);
    localparam int J_W       = $clog2(N_POINT + DRAIN_LEN) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    typedef struct packed {
        logic            valid;
        logic            sof;
        logic            eof;
        logic [TW_W-1:0] tw;
    } tag_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [DC_W-1:0]  dcnt, dcnt_nx;
    logic             overlap, overlap_nx;
    logic             accept, drop, drain_adv, advance;
    logic [J_W-1:0]   j;
    tag_t             tag_in;
    tag_t             pipe [BF_LAT];

    // Output tag for advance j of a frame; invalid outside the D..N_POINT+D-1 window.
    function automatic tag_t make_tag(input logic [J_W-1:0] idx);
        tag_t           t;
        logic [J_W-1:0] m;
        t = '0;
        m = idx - J_W'(D);
        if (idx >= J_W'(D) && idx <= J_W'(N_POINT + D - 1)) begin
            t.valid = 1'b1;
            t.sof   = (idx == J_W'(D));
            t.eof   = (idx == J_W'(N_POINT + D - 1));
            if (m[SEL_BIT]) begin
                t.tw = TW_W'((m & J_W'(D - 1)) << STAGE);
            end
        end
        return t;
    endfunction

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        dcnt_nx    = dcnt;
        overlap_nx = overlap;
        in_ready   = 1'b0;
        accept     = 1'b0;
        drop       = 1'b0;
        drain_adv  = 1'b0;
        bf_sel     = 1'b0;
        err_sof    = 1'b0;
        j          = '0;

        if (!rst) begin
            unique case (state)
                IDLE: begin
                    in_ready = out_ready;
                    accept   = in_valid & in_ready;
                    drop     = accept & ~in_sof;
                    err_sof  = drop;
                    if (accept && in_sof) begin
                        state_nx   = RUN;
                        cnt_nx     = CNT_W'(1);
                        overlap_nx = 1'b0;
                    end
                end
                RUN: begin
                    in_ready = out_ready;
                    accept   = in_valid & in_ready;
                    bf_sel   = cnt[SEL_BIT];
                    err_sof  = accept & in_sof & (cnt != '0);
                    // While a back-to-back frame starts, its first D advances carry the old frame's tail.
                    if (overlap && cnt < CNT_W'(D)) begin
                        j = J_W'(N_POINT) + J_W'(cnt);
                    end else begin
                        j = J_W'(cnt);
                    end
                    if (accept) begin
                        if (cnt == CNT_W'(N_POINT - 1)) begin
                            state_nx = DRAIN;
                            cnt_nx   = '0;
                            dcnt_nx  = '0;
                        end else begin
                            cnt_nx = cnt + CNT_W'(1);
                        end
                    end
                end
                DRAIN: begin
`ifdef FFT_CTRL_BACK2BACK_EN
                    if (dcnt == '0) begin
                        in_ready = out_ready & in_sof;
                    end
`endif
                    accept    = in_valid & in_ready;
                    drain_adv = out_ready;
                    j         = J_W'(N_POINT) + J_W'(dcnt);
                    if (accept) begin
                        state_nx   = RUN;
                        cnt_nx     = CNT_W'(1);
                        dcnt_nx    = '0;
                        overlap_nx = 1'b1;
                    end else if (drain_adv) begin
                        if (dcnt == DC_W'(DRAIN_LEN - 1)) begin
                            state_nx = IDLE;
                            dcnt_nx  = '0;
                        end else begin
                            dcnt_nx = dcnt + DC_W'(1);
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end

        advance = (accept & ~drop) | drain_adv;
        tag_in  = make_tag(j);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            dcnt    <= '0;
            overlap <= 1'b0;
            // NOTE: the tag pipe is control state, so it is cleared on reset to kill a partial frame.
            for (int i = 0; i < BF_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            dcnt    <= dcnt_nx;
            overlap <= overlap_nx;
            if (advance) begin
                pipe[0] <= tag_in;
                for (int i = 1; i < BF_LAT; i++) begin
                    pipe[i] <= pipe[i-1];
                end
            end
        end
    end

    assign bf_en     = advance;
    assign busy      = !rst && (state != IDLE);
    assign out_valid = pipe[BF_LAT-1].valid;
    assign out_sof   = pipe[BF_LAT-1].sof;
    assign out_eof   = pipe[BF_LAT-1].eof;
    assign tw_addr   = pipe[BF_LAT-1].tw;

endmodule
